nor_02b_bus: RTL and testbench
==============================

Name: nor_02b_bus

Overview:
Bus-form model of a 74xx02 quad 2-input NOR gate for the emulator's logic library. Each output bit is the NOR of the matching a/b bit pair, purely combinational with 4-state (X) semantics preserved. A registered copy of the output is also provided, clocked on the shared clock with an asynchronous active-low reset, for use by synchronous emulator paths.

Parameters:
WIDTH, 4, number of independent NOR gates (bus width); must be >= 1.

Ports:
clk    input   1      system clock; rising edge samples y into y_q
rst_n  input   1      asynchronous, active-low reset of y_q
a      input   WIDTH  gate input A, one bit per gate
b      input   WIDTH  gate input B, one bit per gate
y      output  WIDTH  combinational NOR output, y[i] = ~(a[i] | b[i])
y_q    output  WIDTH  registered copy of y

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- y is combinational, with zero clock latency. It settles within the same simulation time step as an input change, so it is valid at any later time step (#1).
- Each bit is independent. y[i] depends only on a[i] and b[i], and X on other bits must never disturb it.
- Truth table per bit, 4-state:
  - 0,0 -> 1
  - 1,x -> 0, where x is any value including X/Z
  - x,1 -> 0
  - 0,X -> X
  - X,0 -> X
  - X,X -> X
  - Z inputs are treated as X.
- Bits whose inputs are X must drive X on y. They must not be coerced to 0 or 1, because checks use case-equality (===).
- No reset or clock dependency on y. y is valid during reset.
- y_q:
  - rst_n low: y_q = {WIDTH{1'b0}} immediately, with no clock needed.
  - rst_n high: y_q <= y on each rising clk edge, so it lags y by one cycle.
  - Reset release takes effect at the first rising edge after rst_n goes high.
  - X on y propagates into y_q unchanged.
- No internal state other than y_q. There are no handshakes.

Decomposition:
- Shared package: none required. WIDTH is a local parameter of this block only.
- Natural sub-module: nor2_cell, a single-bit 2-input NOR, instantiated WIDTH times via generate. The y_q register stays in the top.
- Other 74xx bus models (and/or/nand) can reuse the same pattern.

Test Plan:
- Per-bit isolation: for i = 0..3, set all other a/b bits to X, a[i]=b[i]=0. Required: y === X except y[i]=1, e.g. i=2 -> 4'bx1xx.
- Single input high: with the setup above, set a[i]=1. Required: y[i]=0 with the other bits X, e.g. i=0 -> 4'bxxx0.
- Both inputs high: set a[i]=1, b[i]=1. Required: y[i]=0 and the other bits remain X.
- Dominance over X: set a[i]=0, b[i]=1, then set a[i]=X with b[i]=1. Required: y[i]=0 in both cases. With a[i]=X and b[i]=0, required: y[i]=X.
- Full-bus known values: a=4'b0101, b=4'b0011 -> y=4'b1000. Then a=0, b=0 -> y=4'b1111.
- Register and reset: pull rst_n low mid-cycle -> y_q=0 at once. Release rst_n, set a=0, b=0 -> y_q=4'b1111 after the first rising clk edge. Pull rst_n low again -> y_q=0 at once, while y still reads 4'b1111.

Source files
------------

// File: rtl/nor_02b_bus_pkg.sv
// Shared constants for the 74xx02 bus-form NOR model.
// Holds the default gate count so the top and any wrappers agree on it.
package nor_02b_bus_pkg;
    localparam int NOR_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/nor_02b_bus_nor2_cell.sv
// Single 2-input NOR gate, combinational, zero latency, no backpressure.
// A 1 on either input forces 0; otherwise X/Z on an input yields X.
module nor_02b_bus_nor2_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a | i_b);
endmodule

// File: rtl/nor_02b_bus.sv
// 74xx02 quad NOR as a bus: y is combinational (0 cycles), y_q lags y by 1 cycle.
// No handshake and no backpressure; y_q clears asynchronously while rst_n is low.
module nor_02b_bus
    import nor_02b_bus_pkg::*;
#(
    parameter int WIDTH = NOR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] r_y_q;

    // One independent cell per bit so X on one lane never reaches another.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        nor_02b_bus_nor2_cell u_cell (
            .i_a (a[g]),
            .i_b (b[g]),
            .o_y (w_y[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_y;
        end
    end

    assign y   = w_y;
    assign y_q = r_y_q;
endmodule

// File: tb/tb_nor_02b_bus.sv
// Directed and randomized checks of nor_02b_bus against a truth-table model.
module tb_nor_02b_bus;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [W-1:0] y_q;

    int checks   = 0;
    int failures = 0;

    nor_02b_bus #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .y     (y),
        .y_q   (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit 4-state NOR from the truth table: any 1 wins, both 0 gives 1, else X.
    function automatic logic [W-1:0] nor_ref(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            if (av[i] === 1'b1 || bv[i] === 1'b1)
                r[i] = 1'b0;
            else if (av[i] === 1'b0 && bv[i] === 1'b0)
                r[i] = 1'b1;
            else
                r[i] = 1'bx;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_3state();
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ($urandom_range(0, 2))
                0:       r[i] = 1'b0;
                1:       r[i] = 1'b1;
                default: r[i] = 1'bx;
            endcase
        end
        return r;
    endfunction

    task automatic check_bus(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    logic [W-1:0] exp_q;
    bit           rst_this;

    initial begin
        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check_bus("reset_yq", y_q, 4'b0000);
        check_bus("reset_y_valid", y, 4'b1111);

        // Per-bit isolation with the other lanes driven X.
        for (int i = 0; i < W; i++) begin
            a = 'x; b = 'x;
            a[i] = 1'b0; b[i] = 1'b0;
            #1;
            check_bit($sformatf("iso00_bit%0d", i), y[i], 1'b1);
            check_bus($sformatf("iso00_bus%0d", i), y, nor_ref(a, b));
            a[i] = 1'b1;
            #1;
            check_bit($sformatf("iso10_bit%0d", i), y[i], 1'b0);
            check_bus($sformatf("iso10_bus%0d", i), y, nor_ref(a, b));
            b[i] = 1'b1;
            #1;
            check_bit($sformatf("iso11_bit%0d", i), y[i], 1'b0);
            check_bus($sformatf("iso11_bus%0d", i), y, nor_ref(a, b));
            a[i] = 1'b0;
            #1;
            check_bit($sformatf("dom01_bit%0d", i), y[i], 1'b0);
            a[i] = 1'bx;
            #1;
            check_bit($sformatf("domx1_bit%0d", i), y[i], 1'b0);
            b[i] = 1'b0;
            #1;
            check_bus($sformatf("x0_bus%0d", i), y, nor_ref(a, b));
        end

        a = 4'b0101; b = 4'b0011;
        #1;
        check_bus("full_0101_0011", y, 4'b1000);
        a = 4'b0000; b = 4'b0000;
        #1;
        check_bus("full_zero", y, 4'b1111);
        check_bus("yq_held_in_reset", y_q, 4'b0000);

        // Register behaviour around reset.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_bus("yq_after_release", y_q, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check_bus("yq_async_reset", y_q, 4'b0000);
        check_bus("y_during_reset", y, 4'b1111);

        // Randomized traffic with occasional reset pulses.
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst_this = ($urandom_range(0, 15) == 0);
            rst_n = !rst_this;
            a = rand_3state();
            b = rand_3state();
            #1;
            check_bus("rand_y", y, nor_ref(a, b));
            exp_q = rst_this ? '0 : nor_ref(a, b);
            if (rst_this)
                check_bus("rand_yq_async", y_q, 4'b0000);
            @(posedge clk);
            #1;
            check_bus("rand_yq", y_q, exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
